// File: rtl/soc_system_uart_data_out_fifo.sv
// Avalon-MM receive FIFO: buffers UART receiver bytes for HPS reads through DATA/STATUS/CONTROL.
// Optional interrupt output and CONTROL[1] irq_en enabled by defining SOC_UART_RX_IRQ_EN.
module soc_system_uart_data_out_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              read_n,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready
`ifdef SOC_UART_RX_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam int unsigned PTR_W = DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  localparam logic [1:0] ADDR_DATA    = 2'd0;
  localparam logic [1:0] ADDR_STATUS  = 2'd1;
  localparam logic [1:0] ADDR_CONTROL = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_overflow;

  logic w_rd;
  logic w_wr;
  logic w_full;
  logic w_empty;
  logic w_flush;
  logic w_push;
  logic w_pop;
  logic w_ovf_set;
  logic w_ovf_clr;
  logic [7:0] w_head;
  logic w_unused;

  assign w_rd      = chipselect & ~read_n;
  assign w_wr      = chipselect & ~write_n;
  assign w_full    = (r_level == LVL_W'(DEPTH));
  assign w_empty   = (r_level == LVL_W'(0));
  assign w_flush   = w_wr & (address == ADDR_CONTROL) & writedata[0];
  assign w_push    = in_valid & ~w_full & ~w_flush;
  assign w_pop     = w_rd & (address == ADDR_DATA) & ~w_empty & ~w_flush;
  // A byte discarded by a flush is intentional, so it does not count as an overflow.
  assign w_ovf_set = in_valid & w_full & ~w_flush;
  assign w_ovf_clr = w_wr & (address == ADDR_STATUS) & writedata[18];
  assign w_head    = 8'(r_mem[r_rd_ptr]);
  assign w_unused  = ^writedata;
  assign in_ready  = ~w_full;

  // Storage carries no reset; the level counter alone decides what is readable.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_pop) begin
        r_level <= r_level + LVL_W'(1);
      end else if (!w_push && w_pop) begin
        r_level <= r_level - LVL_W'(1);
      end
    end
  end

  // Sticky overflow; a new drop wins over a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_ovf_set) begin
      r_overflow <= 1'b1;
    end else if (w_ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

`ifdef SOC_UART_RX_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (address == ADDR_CONTROL)) begin
        r_irq_en <= writedata[1];
      end
      r_irq <= r_irq_en & (~w_empty | r_overflow);
    end
  end

  assign irq = r_irq;
`endif

  // Zero-wait read mux.
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA: begin
        if (!w_empty) begin
          readdata[8]   = 1'b1;
          readdata[7:0] = w_head;
        end
      end
      ADDR_STATUS: begin
        readdata[LVL_W-1:0] = r_level;
        readdata[16]        = w_empty;
        readdata[17]        = w_full;
        readdata[18]        = r_overflow;
      end
      ADDR_CONTROL: begin
`ifdef SOC_UART_RX_IRQ_EN
        readdata[1] = r_irq_en;
`endif
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_soc_system_uart_data_out_fifo.sv
// Scoreboard bench for soc_system_uart_data_out_fifo: queue-based reference model, directed and random traffic.
module tb_soc_system_uart_data_out_fifo;

  localparam int unsigned DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  address = 2'd0;
  logic        chipselect = 1'b0;
  logic        read_n = 1'b1;
  logic        write_n = 1'b1;
  logic [31:0] writedata = 32'h0;
  logic [31:0] readdata;
  logic [7:0]  in_data = 8'h0;
  logic        in_valid = 1'b0;
  logic        in_ready;
`ifdef SOC_UART_RX_IRQ_EN
  logic        irq;
`endif

  soc_system_uart_data_out_fifo #(.DEPTH_LOG2(4), .DATA_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
`ifdef SOC_UART_RX_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_rd;
    logic [31:0] rdata;
    logic        rdy;
    logic        irq;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_irq_en = 1'b0;
  logic       m_irq = 1'b0;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %08h expected %08h", name, $time, act, req);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    logic [31:0] v;
    v = 32'h0;
    case (a)
      2'd0: if (mq.size() > 0) v = 32'h100 | 32'(mq[0]);
      2'd1: begin
        v = 32'(mq.size());
        if (mq.size() == 0) v = v | 32'h1_0000;
        if (mq.size() == DEPTH) v = v | 32'h2_0000;
        if (m_ovf) v = v | 32'h4_0000;
      end
      2'd2: if (m_irq_en) v = 32'h2;
      default: v = 32'h0;
    endcase
    return v;
  endfunction

  task automatic model_step(input logic r, input logic w, input logic [1:0] a,
                            input logic [31:0] wd, input logic v, input logic [7:0] d);
    logic full, empty, flush, nxt_irq;
    full    = (mq.size() == DEPTH);
    empty   = (mq.size() == 0);
    flush   = w && (a == 2'd2) && wd[0];
    nxt_irq = m_irq_en && (!empty || m_ovf);
    if (flush) begin
      mq.delete();
    end else begin
      if (r && (a == 2'd0) && !empty) void'(mq.pop_front());
      if (v && !full) mq.push_back(d);
    end
    if (v && full && !flush) m_ovf = 1'b1;
    else if (w && (a == 2'd1) && wd[18]) m_ovf = 1'b0;
`ifdef SOC_UART_RX_IRQ_EN
    if (w && (a == 2'd2)) m_irq_en = wd[1];
`endif
    m_irq = nxt_irq;
  endtask

  // One bus/receiver cycle: expectation from pre-edge model state, then advance the model at the edge.
  task automatic cyc(input logic r, input logic w, input logic [1:0] a,
                     input logic [31:0] wd, input logic v, input logic [7:0] d);
    exp_t e;
    chipselect = r | w;
    read_n     = ~r;
    write_n    = ~w;
    address    = a;
    writedata  = wd;
    in_valid   = v;
    in_data    = d;
    e.chk_rd   = r;
    e.rdata    = r ? model_read(a) : 32'h0;
    e.rdy      = (mq.size() != DEPTH);
    e.irq      = m_irq;
    exp_q.push_back(e);
    @(posedge clk);
    model_step(r, w, a, wd, v, d);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic push(input logic [7:0] d);
    cyc(1'b0, 1'b0, 2'd0, 32'h0, 1'b1, d);
  endtask

  task automatic rd(input logic [1:0] a);
    cyc(1'b1, 1'b0, a, 32'h0, 1'b0, 8'h0);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] wd);
    cyc(1'b0, 1'b1, a, wd, 1'b0, 8'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    chipselect = 1'b0;
    read_n = 1'b1;
    write_n = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();
    m_ovf = 1'b0;
    m_irq_en = 1'b0;
    m_irq = 1'b0;
    reset = 1'b0;
  endtask

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.chk_rd) chk("readdata", readdata, e.rdata);
      chk("in_ready", 32'(in_ready), 32'(e.rdy));
`ifdef SOC_UART_RX_IRQ_EN
      chk("irq", 32'(irq), 32'(e.irq));
`endif
    end
  end

  initial begin
    do_reset();

    // Reset state
    rd(2'd1);
    rd(2'd0);

    // Three bytes in, three out
    push(8'h41); push(8'h42); push(8'h43);
    rd(2'd1);
    rd(2'd0); rd(2'd0); rd(2'd0);
    rd(2'd1);

    // Overfill, drain, clear overflow
    for (int i = 0; i < 17; i++) push(8'(i));
    rd(2'd1);
    for (int i = 0; i < 16; i++) rd(2'd0);
    rd(2'd1);
    wr(2'd1, 32'h0004_0000);
    rd(2'd1);

    // Full with same-cycle pop and in_valid
    for (int i = 0; i < 16; i++) push(8'(8'h80 + i));
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 8'hEE);
    rd(2'd1);
    wr(2'd2, 32'h1);
    wr(2'd1, 32'h0004_0000);

    // Level 5 with same-cycle push and pop
    for (int i = 0; i < 5; i++) push(8'(8'h10 + i));
    cyc(1'b1, 1'b0, 2'd0, 32'h0, 1'b1, 8'h99);
    rd(2'd1);
    for (int i = 0; i < 6; i++) rd(2'd0);

    // Flush at level 8 with same-cycle in_valid
    for (int i = 0; i < 8; i++) push(8'(8'h30 + i));
    cyc(1'b0, 1'b1, 2'd2, 32'h1, 1'b1, 8'h77);
    rd(2'd1);
    rd(2'd0);
    rd(2'd2);

    // Writes to DATA and reserved address are ignored; address 3 reads 0
    push(8'h5A);
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd3);
    rd(2'd1);
    rd(2'd0);

`ifdef SOC_UART_RX_IRQ_EN
    wr(2'd2, 32'h2);
    rd(2'd2);
    push(8'h55);
    idle(); idle();
    rd(2'd0);
    idle(); idle();
    wr(2'd2, 32'h0);
    push(8'h56);
    idle(); idle();
    rd(2'd0);
    idle();
`endif

    // Reset in the middle of traffic
    for (int i = 0; i < 6; i++) push(8'(8'hC0 + i));
    do_reset();
    rd(2'd1);
    rd(2'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int unsigned k, pct;
      logic v;
      logic [7:0] d;
      pct = ((i / 400) % 2 == 1) ? 85 : 30;
      k = $urandom_range(0, 99);
      v = ($urandom_range(0, 99) < pct);
      d = 8'($urandom);
      if (k < 35)      cyc(1'b1, 1'b0, 2'd0, 32'h0, v, d);
      else if (k < 45) cyc(1'b1, 1'b0, 2'd1, 32'h0, v, d);
      else if (k < 48) cyc(1'b1, 1'b0, 2'd2, 32'h0, v, d);
      else if (k < 49) cyc(1'b1, 1'b0, 2'd3, 32'h0, v, d);
      else if (k < 51) cyc(1'b0, 1'b1, 2'd2, $urandom, v, d);
      else if (k < 53) cyc(1'b0, 1'b1, 2'd1, $urandom, v, d);
      else if (k < 55) cyc(1'b0, 1'b1, 2'($urandom_range(0, 1) * 3), $urandom, v, d);
      else             cyc(1'b0, 1'b0, 2'd0, 32'h0, v, d);
    end

    idle();
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
